// File: rtl/uart_io_pkg.sv
// Shared definitions for the UART IO hub: register offsets, STATUS bit
// positions, the FSM state encoding used by both TX and RX, and limits.
package uart_io_pkg;

  localparam logic [1:0] REG_LEDS   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  localparam int STAT_TX_FULL      = 0;
  localparam int STAT_TX_IDLE      = 1;
  localparam int STAT_RX_VALID     = 2;
  localparam int STAT_RX_OVERRUN   = 3;
  localparam int STAT_FRAME_ERR    = 4;
  localparam int STAT_TX_LEVEL_LSB = 8;
  localparam int STAT_RX_LEVEL_LSB = 16;

  // Smaller divisors leave no room for the half-bit start sample in RX.
  localparam logic [15:0] MIN_BAUD_DIV = 16'd4;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uartState_e;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with occupancy level. A push into a full FIFO is only
// accepted when a pop happens in the same cycle, so the level stays put.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [LW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];
  assign level   = count;

  // Pointer and occupancy bookkeeping; reset discards any stored entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/uart_io_hub.sv
// Memory-mapped IO hub: LED register plus a buffered full-duplex 8N1 UART
// with a runtime baud divisor and sticky RX error flags.
module uart_io_hub
  import uart_io_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int LED_W       = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [31:0]      IO_memAddr_i,
  input  logic [31:0]      IO_memWData_i,
  input  logic             IO_memWr_i,
  input  logic             IO_memRd_i,
  output logic [31:0]      IO_memRData_o,
  output logic [LED_W-1:0] leds_o,
  input  logic             rxd_i,
  output logic             txd_o
);

  localparam int          LVW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] RESET_DIV = 16'(CLK_FREQ_HZ / BAUD);

  logic [1:0]       regSel;
  logic [LED_W-1:0] ledReg;
  logic [15:0]      baudDiv;
  logic             rxOverrun, frameErr;
  logic             statusWr, unusedBits;

  logic             txPush, txPop, txFull, txEmpty;
  logic [7:0]       txData;
  logic [LVW-1:0]   txLevel;
  uartState_e       txState, txNext;
  logic [15:0]      txCnt, txBitLen;
  logic [2:0]       txBitIdx;
  logic [7:0]       txShift;
  logic             txdReg, txBitEnd;

  logic             rxMeta, rxSync, rxPrev, rxFall;
  uartState_e       rxState, rxNext;
  logic [15:0]      rxCnt, rxBitLen;
  logic [2:0]       rxBitIdx;
  logic [7:0]       rxShift, rxData;
  logic             rxHit, rxPush, rxPop, rxFull, rxEmpty, frameEvt;
  logic [LVW-1:0]   rxLevel;

  assign regSel     = IO_memAddr_i[3:2];
  assign statusWr   = IO_memWr_i && (regSel == REG_STATUS);
  assign txPush     = IO_memWr_i && (regSel == REG_DATA);
  assign rxPop      = IO_memRd_i && (regSel == REG_DATA) && !rxEmpty;
  assign leds_o     = ledReg;
  assign txd_o      = txdReg;
  assign unusedBits = ^{IO_memAddr_i[31:4], IO_memAddr_i[1:0], IO_memWData_i};

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
    .clk(clk_i), .rst_n(reset_i), .push(txPush), .pushData(IO_memWData_i[7:0]),
    .pop(txPop), .popData(txData), .full(txFull), .empty(txEmpty), .level(txLevel)
  );

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rxFifo (
    .clk(clk_i), .rst_n(reset_i), .push(rxPush), .pushData(rxShift),
    .pop(rxPop), .popData(rxData), .full(rxFull), .empty(rxEmpty), .level(rxLevel)
  );

  // LED and baud divisor registers; tiny divisors are clamped on write.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ledReg  <= '0;
      baudDiv <= RESET_DIV;
    end else if (IO_memWr_i) begin
      if (regSel == REG_LEDS) ledReg <= IO_memWData_i[LED_W-1:0];
      if (regSel == REG_BAUD)
        baudDiv <= (IO_memWData_i[15:0] < MIN_BAUD_DIV) ? MIN_BAUD_DIV : IO_memWData_i[15:0];
    end
  end

  // Sticky error flags: a STATUS write clears them, a new event wins.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rxOverrun <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      rxOverrun <= (rxOverrun && !statusWr) || (rxPush && rxFull && !rxPop);
      frameErr  <= (frameErr && !statusWr) || frameEvt;
    end
  end

  // Read data is a pure function of the current address.
  always_comb begin
    IO_memRData_o = '0;
    case (regSel)
      REG_LEDS: IO_memRData_o = 32'(ledReg);
      REG_DATA: IO_memRData_o = {23'b0, !rxEmpty, rxEmpty ? 8'h00 : rxData};
      REG_STATUS: begin
        IO_memRData_o[STAT_TX_FULL]    = txFull;
        IO_memRData_o[STAT_TX_IDLE]    = txEmpty && (txState == UART_IDLE);
        IO_memRData_o[STAT_RX_VALID]   = !rxEmpty;
        IO_memRData_o[STAT_RX_OVERRUN] = rxOverrun;
        IO_memRData_o[STAT_FRAME_ERR]  = frameErr;
        IO_memRData_o[STAT_TX_LEVEL_LSB +: 8] = 8'(txLevel);
        IO_memRData_o[STAT_RX_LEVEL_LSB +: 8] = 8'(rxLevel);
      end
      default:  IO_memRData_o = {16'b0, baudDiv};
    endcase
  end

  // TX state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) txState <= UART_IDLE;
    else          txState <= txNext;
  end

  // TX next state; frames chain back-to-back when the FIFO still holds data.
  always_comb begin
    txNext   = txState;
    txPop    = 1'b0;
    txBitEnd = (txState != UART_IDLE) && (txCnt == txBitLen - 16'd1);
    case (txState)
      UART_IDLE:  if (!txEmpty) begin txPop = 1'b1; txNext = UART_START; end
      UART_START: if (txBitEnd) txNext = UART_DATA;
      UART_DATA:  if (txBitEnd && txBitIdx == 3'd7) txNext = UART_STOP;
      default: begin
        if (txBitEnd) begin
          if (!txEmpty) begin txPop = 1'b1; txNext = UART_START; end
          else txNext = UART_IDLE;
        end
      end
    endcase
  end

  // TX datapath: bit timer, shift register and registered serial line.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      txCnt    <= '0;
      txBitLen <= RESET_DIV;
      txBitIdx <= '0;
      txShift  <= '0;
      txdReg   <= 1'b1;
    end else begin
      if (txState == UART_IDLE || txBitEnd) txCnt <= '0;
      else txCnt <= txCnt + 16'd1;
      if (txPop || txBitEnd) txBitLen <= baudDiv;
      if (txPop) begin
        txdReg   <= 1'b0;
        txShift  <= txData;
        txBitIdx <= '0;
      end else if (txBitEnd) begin
        case (txState)
          UART_START: begin
            txdReg  <= txShift[0];
            txShift <= txShift >> 1;
          end
          UART_DATA: begin
            txdReg   <= (txBitIdx == 3'd7) ? 1'b1 : txShift[0];
            txShift  <= txShift >> 1;
            txBitIdx <= txBitIdx + 3'd1;
          end
          default: txdReg <= 1'b1;
        endcase
      end
    end
  end

  // RX input synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rxd_i;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  assign rxFall = rxPrev && !rxSync;

  // RX state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rxState <= UART_IDLE;
    else          rxState <= rxNext;
  end

  // RX next state: half-bit start check, then full-bit sampling.
  always_comb begin
    rxNext   = rxState;
    rxPush   = 1'b0;
    frameEvt = 1'b0;
    case (rxState)
      UART_START: rxHit = (rxCnt == (rxBitLen >> 1) - 16'd1);
      UART_IDLE:  rxHit = 1'b0;
      default:    rxHit = (rxCnt == rxBitLen - 16'd1);
    endcase
    case (rxState)
      UART_IDLE:  if (rxFall) rxNext = UART_START;
      UART_START: if (rxHit) rxNext = rxSync ? UART_IDLE : UART_DATA;
      UART_DATA:  if (rxHit && rxBitIdx == 3'd7) rxNext = UART_STOP;
      default: begin
        if (rxHit) begin
          rxNext   = UART_IDLE;
          rxPush   = rxSync;
          frameEvt = !rxSync;
        end
      end
    endcase
  end

  // RX datapath: bit timer and LSB-first shift register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rxCnt    <= '0;
      rxBitLen <= RESET_DIV;
      rxBitIdx <= '0;
      rxShift  <= '0;
    end else if (rxState == UART_IDLE) begin
      rxCnt <= '0;
      if (rxFall) rxBitLen <= baudDiv;
    end else if (rxHit) begin
      rxCnt    <= '0;
      rxBitLen <= baudDiv;
      if (rxState == UART_START) rxBitIdx <= '0;
      if (rxState == UART_DATA) begin
        rxShift  <= {rxSync, rxShift[7:1]};
        rxBitIdx <= rxBitIdx + 3'd1;
      end
    end else begin
      rxCnt <= rxCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_io_hub.sv
// Scoreboard bench for uart_io_hub: stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_uart_io_hub;

  localparam logic [31:0] A_LEDS   = 32'h0;
  localparam logic [31:0] A_DATA   = 32'h4;
  localparam logic [31:0] A_STATUS = 32'h8;
  localparam logic [31:0] A_BAUD   = 32'hC;
  localparam int K_RDATA = 0;
  localparam int K_TXD   = 1;
  localparam int K_LEDS  = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [31:0] memAddr = '0;
  logic [31:0] memWData = '0;
  logic        memWr = 1'b0;
  logic        memRd = 1'b0;
  logic [31:0] memRData;
  logic [3:0]  leds;
  logic        txd;
  logic        rxd;
  logic        rxDrive = 1'b1;
  logic        loopBack = 1'b0;

  int          kindQ[$];
  logic [31:0] expQ[$];
  string       nameQ[$];
  logic        chkReq = 1'b0;
  int          checks = 0;
  int          passed = 0;

  int          monKind;
  logic [31:0] monExp;
  logic [31:0] monAct;
  string       monName;

  assign rxd = loopBack ? txd : rxDrive;

  uart_io_hub #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(resetN), .IO_memAddr_i(memAddr), .IO_memWData_i(memWData),
    .IO_memWr_i(memWr), .IO_memRd_i(memRd), .IO_memRData_o(memRData),
    .leds_o(leds), .rxd_i(rxd), .txd_o(txd)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Monitor: on each requested sample point pop one expectation and compare.
  always @(negedge clk) begin
    if (chkReq) begin
      checks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL scoreboard-underflow: sample requested with no expected value");
      end else begin
        monKind = kindQ.pop_front();
        monExp  = expQ.pop_front();
        monName = nameQ.pop_front();
        case (monKind)
          K_TXD:   monAct = {31'b0, txd};
          K_LEDS:  monAct = {28'b0, leds};
          default: monAct = memRData;
        endcase
        if (monAct === monExp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", monName, monAct, monExp);
      end
    end
  end

  // Safety net so a hang still ends the run.
  initial begin
    #200us;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data);
    memAddr  = addr;
    memWData = data;
    memWr    = wr;
    memRd    = rd;
    tick();
    memWr = 1'b0;
    memRd = 1'b0;
  endtask

  task automatic checkOutput(input int kind, input logic [31:0] addr, input logic rd,
                             input logic [31:0] expVal, input string nm);
    memAddr = addr;
    memRd   = rd;
    kindQ.push_back(kind);
    expQ.push_back(expVal);
    nameQ.push_back(nm);
    chkReq = 1'b1;
    tick();
    chkReq = 1'b0;
    memRd  = 1'b0;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    $display("[TB] starting uart_io_hub bench");
    repeat (3) tick();
    checkOutput(K_TXD, A_STATUS, 1'b0, 32'h1, "reset-txd-held");
    resetN = 1'b1;
    tick();
    checkOutput(K_TXD,   A_STATUS, 1'b0, 32'h1,        "reset-txd");
    checkOutput(K_LEDS,  A_STATUS, 1'b0, 32'h0,        "reset-leds");
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h2,        "reset-status");
    checkOutput(K_RDATA, A_BAUD,   1'b0, 32'd104,      "reset-baud");

    applyStimulus(1'b1, 1'b0, A_LEDS, 32'hFFFF_FFF5);
    checkOutput(K_LEDS,  A_LEDS, 1'b0, 32'h5, "leds-pins");
    checkOutput(K_RDATA, A_LEDS, 1'b0, 32'h5, "leds-readback");
    applyStimulus(1'b1, 1'b0, A_BAUD, 32'h0);
    checkOutput(K_RDATA, A_BAUD, 1'b0, 32'h4, "baud-clamp");

    // 0x55 at 4 clocks/bit: start, LSB-first data, stop alternate 0/1.
    applyStimulus(1'b1, 1'b0, A_DATA, 32'h55);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      checkOutput(K_TXD, A_STATUS, 1'b0, {31'b0, k[0]}, $sformatf("tx55-bit%0d", k));
      if (k == 5) checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h0, "tx-busy-status");
      else tick();
      tick();
      tick();
    end
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h2, "tx-idle-after-frame");

    loopBack = 1'b1;
    applyStimulus(1'b1, 1'b0, A_DATA, 32'hA3);
    applyStimulus(1'b1, 1'b0, A_DATA, 32'h0F);
    repeat (130) tick();
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h0002_0006, "loop-status");
    checkOutput(K_RDATA, A_DATA,   1'b1, 32'h1A3,       "loop-rx0");
    checkOutput(K_RDATA, A_DATA,   1'b1, 32'h10F,       "loop-rx1");
    checkOutput(K_RDATA, A_DATA,   1'b1, 32'h000,       "loop-rx-empty");
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h2,         "loop-status-drained");

    for (int b = 1; b <= 5; b++) applyStimulus(1'b1, 1'b0, A_DATA, 32'h11 * b);
    repeat (260) tick();
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h0004_000E, "overrun-status");
    applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h0004_0006, "overrun-cleared");
    for (int b = 1; b <= 4; b++)
      checkOutput(K_RDATA, A_DATA, 1'b1, 32'h100 | (32'h11 * b), $sformatf("overrun-rx%0d", b));
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h2, "overrun-drained");

    loopBack = 1'b0;
    rxDrive  = 1'b0;
    repeat (40) tick();
    rxDrive = 1'b1;
    repeat (10) tick();
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h12, "frame-error");
    applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h2, "frame-error-cleared");
    rxDrive = 1'b0;
    tick();
    rxDrive = 1'b1;
    repeat (20) tick();
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h2, "glitch-ignored");

    applyStimulus(1'b1, 1'b0, A_DATA, 32'h00);
    repeat (6) tick();
    checkOutput(K_TXD, A_STATUS, 1'b0, 32'h0, "tx-mid-frame");
    resetN = 1'b0;
    checkOutput(K_TXD,   A_STATUS, 1'b0, 32'h1,   "reset-abort-txd");
    checkOutput(K_RDATA, A_STATUS, 1'b0, 32'h2,   "reset-abort-status");
    resetN = 1'b1;
    tick();
    checkOutput(K_RDATA, A_BAUD, 1'b0, 32'd104, "reset-abort-baud");
    checkOutput(K_LEDS,  A_BAUD, 1'b0, 32'h0,   "reset-abort-leds");
    repeat (20) tick();
    checkOutput(K_TXD, A_STATUS, 1'b0, 32'h1, "reset-fifo-flushed");

    tick();
    checks++;
    if (expQ.size() == 0) passed++;
    else $display("[TB] FAIL scoreboard-leftover: got %0d pending expected 0", expQ.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_io_hub.md
# uart_io_hub

Memory-mapped IO peripheral for the SoC's IO bus, succeeding the fixed LED/TX-only IO block. Parametrised LED width and FIFO depth. Full-duplex 8N1 UART: buffered TX, new RX path on `RXD`, runtime-programmable baud divisor, and sticky error flags. Sits between the processor's IO bus and the board pins (`LEDS`, `TXD`, `RXD`).

## Interface
- `CLK_FREQ_HZ`, 12000000: core clock frequency.
- `BAUD`, 115200: baud rate at reset; `BAUD_DIV` reset value = CLK_FREQ_HZ/BAUD (integer divide).
- `FIFO_DEPTH`, 16: entries per TX and RX FIFO; power of two, 2..128.
- `LED_W`, 4: LED output width, 1..32.
- `clk_i`  in  1  core clock.
- `reset_i`  in  1  asynchronous, active-low reset. One clock; reset asynchronous and active-low.
- `IO_memAddr_i`  in  32  byte address; register select = bits [3:2].
- `IO_memWData_i`  in  32  write data.
- `IO_memWr_i`  in  1  write strobe, one cycle per access.
- `IO_memRd_i`  in  1  read strobe, one cycle per access; side effects only on this.
- `IO_memRData_o`  out  32  read data, combinational from address.
- `leds_o`  out  LED_W  LED register.
- `rxd_i`  in  1  asynchronous serial input.
- `txd_o`  out  1  serial output, registered.

## Operation
- Register map by `IO_memAddr_i[3:2]`:
  - 0 LEDS: R/W, low LED_W bits.
  - 1 DATA: write pushes `WData[7:0]` to TX FIFO; dropped silently if full. Read returns {23'b0, rx_valid, rx_byte}. `IO_memRd_i` pops RX FIFO only if non-empty.
  - 2 STATUS: [0] tx_full, [1] tx_idle (FIFO empty and FSM idle), [2] rx_valid, [3] rx_overrun (sticky), [4] frame_err (sticky), [15:8] tx_level, [23:16] rx_level. Any write clears bits 3 and 4.
  - 3 BAUD_DIV: R/W, clocks per bit, 16 bits. Values below 4 are stored as 4.
- TX FSM states: IDLE, START, DATA (8 bits, LSB first), STOP.
  - Each state lasts BAUD_DIV clocks.
  - In IDLE, a non-empty FIFO pops one byte and enters START.
- RX input: `rxd_i` passes through a 2-flop synchroniser.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE to START on a synchronised high-to-low transition.
  - Start bit is sampled BAUD_DIV/2 clocks after the edge. If high, treat as a glitch and return to IDLE.
  - Data bits are sampled every BAUD_DIV clocks thereafter, LSB first.
  - Stop bit: if high, push the byte; if low, set frame_err, discard the byte, and return to IDLE.
- RX push into a full FIFO: drop the byte, set rx_overrun.
- Simultaneous pop and push on the same FIFO in the same cycle: both take effect and the level is unchanged. Applies to RX (bus read plus RX completion) and TX (bus write plus FSM pop).
- A BAUD_DIV write mid-frame takes effect at the next bit boundary.

## Timing
- Reset values:
  - `leds_o` = 0, `txd_o` = 1.
  - Both FIFOs empty; both FSMs IDLE.
  - Flags = 0; BAUD_DIV = CLK_FREQ_HZ/BAUD.
- Reset asserted mid-frame aborts immediately: `txd_o` goes to 1 asynchronously and FIFO contents are lost.
- DATA write at edge N into an empty TX FIFO with an idle FSM: `txd_o` falls after edge N+1.
- A TX frame is 10×BAUD_DIV clocks. The next frame's start bit follows the stop bit with no gap.
- RX byte is visible (`rx_valid` = 1) 2 (sync) + 9.5×BAUD_DIV clocks (±1) after the start edge reaches the pin.
- `IO_memRData_o` is valid in the same cycle as the address. A pop on `IO_memRd_i` at edge N shows the next entry from N+1.
- LEDS write at edge N: `leds_o` updates after edge N.

## Structure
- Package `uart_io_pkg`:
  - Register offsets REG_LEDS/REG_DATA/REG_STATUS/REG_BAUD.
  - STATUS bit indices.
  - Shared TX/RX FSM state enum.
  - MIN_BAUD_DIV = 4.
- Sub-module `io_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/level), instantiated for TX and RX.
- TX and RX FSMs are inline in `uart_io_hub`.

## Test plan
- Reset: `txd_o` = 1, `leds_o` = 0, STATUS = 0x0000_0002, BAUD_DIV = 104 with defaults.
- Write BAUD_DIV = 4, then DATA 0x55: `txd_o` = 0,1,0,1,0,1,0,1,0,1 with each level held 4 clocks; STATUS bit 1 returns to 1 after 40 clocks.
- Loop `txd_o` to `rxd_i` and send 0xA3, 0x0F: rx_level = 2; reads return 0x1A3, then 0x10F, then 0x000.
- With FIFO_DEPTH = 4, receive 5 bytes without reading: rx_level = 4, bit 3 set, first 4 bytes intact. A STATUS write clears bit 3.
- Drive a frame with the stop bit low: bit 4 = 1 and rx_level unchanged. A 1-clock low glitch on `rxd_i` produces no byte and no error.
- Write 0 to BAUD_DIV: reads back 4. Write LEDS 0xFFFF_FFF5: `leds_o` = 4'h5. Assert reset mid-TX: `txd_o` = 1 immediately.
